tiger_dmem_responder: RTL and testbench
=======================================

Name: tiger_dmem_responder

Overview:
Responder end of the execute-stage data-memory request interface. It accepts memread/memwrite/mem16/mem8/memaddress/memwritedata requests and drives the memCanRead/memCanWrite/canDCacheFlush readiness signals back to execute. It turns each request into Avalon-MM master transactions and returns the read word to the memory-access (MA) stage. Writes are posted through a one-entry write buffer, and a data-cache flush acts as an ordering barrier.

Parameters:
ADDR_WIDTH, 32, width of memaddress and avm_address (byte address)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
memread  in  1  read request; execute gates it with memCanRead
memwrite  in  1  write request; execute gates it with memCanWrite
mem16  in  1  halfword access
mem8  in  1  byte access
memaddress  in  ADDR_WIDTH  byte address
memwritedata  in  32  store data, right-justified
dCacheFlush  in  1  flush request; execute gates it with canDCacheFlush
memCanRead  out  1  read may be accepted this cycle
memCanWrite  out  1  write may be accepted this cycle
canDCacheFlush  out  1  flush may be accepted this cycle
memReadData  out  32  raw aligned word; lane extraction and sign extension happen in MA
memReadValid  out  1  one-cycle pulse; memReadData is valid
avm_address  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_byteenable  out  4  lane enables
avm_writedata  out  32  lane-replicated data
avm_readdata  in  32  read data
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  read data valid
dcFlushOut  out  1  one-cycle flush pulse to downstream cache
dcFlushDone  in  1  downstream flush complete

Behaviour:
- Reset values: every output is 0 except memCanRead=1, memCanWrite=1, canDCacheFlush=1. State goes to IDLE and the write buffer is emptied.
- FSM states:
  - IDLE, RD_ISSUE, RD_WAIT, FL_PULSE, FL_WAIT.
  - Write buffer (wb_valid, address, byteenable, data) is a separate register set.
- Readiness (combinational):
  - memCanRead = (state==IDLE) && !wb_valid.
  - memCanWrite = (state==IDLE || state==RD_ISSUE || state==RD_WAIT) && (!wb_valid || wb_drain), where wb_drain = avm_write && !avm_waitrequest.
  - canDCacheFlush = (state==IDLE) && !wb_valid.
- Byte enables:
  - Byte access (mem8): 4'b0001 << addr[1:0].
  - Halfword access (mem16): addr[1] ? 4'b1100 : 4'b0011.
  - Otherwise 4'b1111.
  - If mem8 and mem16 are both set, mem8 wins.
- Write data replication: byte = {4{d[7:0]}}; halfword = {2{d[15:0]}}; word = d.
- Write path:
  - An accepted memwrite loads the buffer on the next edge.
  - avm_write = wb_valid && state==IDLE.
  - The buffer entry is held until !avm_waitrequest.
  - A new write in the same cycle as the drain reloads the buffer with no bubble.
- Read path:
  - memread is accepted in IDLE; it latches the address and moves to RD_ISSUE.
  - RD_ISSUE: avm_read=1 and is held while avm_waitrequest. On !avm_waitrequest, move to RD_WAIT.
  - RD_WAIT: on avm_readdatavalid, register avm_readdata into memReadData, pulse memReadValid for 1 cycle, and return to IDLE.
  - Minimum latency with zero wait and 1-cycle read latency: 3 cycles from accept to memReadValid.
  - memReadData holds its value until the next read.
- Ordering: a read is never accepted while wb_valid, so stores drain before later loads.
- Flush path:
  - Accept in IDLE with an empty buffer, then go to FL_PULSE: dcFlushOut=1 for exactly 1 cycle.
  - Then FL_WAIT until dcFlushDone, then IDLE.
  - dcFlushDone arriving in the FL_PULSE cycle is honoured.
- avm_readdatavalid seen outside RD_WAIT is ignored.
- Reset mid-operation: avm_read/avm_write drop on the next edge, and pending buffer contents are discarded.
- Simultaneous memread and memwrite is illegal. Assertion only; no defined response.

Optional Feature:
TIGER_DMEM_MISALIGN_TRAP_EN.
- Defined: adds output addrError (1 bit, registered, 1-cycle pulse).
  - Triggers on a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
  - The request is accepted but no bus transaction is issued.
  - For a misaligned read, memReadValid still pulses on the next cycle with memReadData=0, so MA never deadlocks.
- Undefined: no addrError port. The low address bits are ignored for word access, and for halfword access only addr[1] selects the lane.

Decomposition:
- Shared tiger_defines: state encodings (DMEM_IDLE, DMEM_RD_ISSUE, DMEM_RD_WAIT, DMEM_FL_PULSE, DMEM_FL_WAIT) and byte-enable constants.
- One natural sub-module: tiger_dmem_lanes, combinational, producing byteenable and replicated writedata from size, addr[1:0] and data. It is reused by the write buffer load path.

Test Plan:
- Word write to 0x100 of 0xDEADBEEF with waitrequest held 2 cycles -> avm_write held 3 cycles, address 0x100, byteenable 1111; memCanWrite high in the drain cycle.
- Byte write to 0x203 of 0x000000A5 -> address 0x200, byteenable 1000, writedata 0xA5A5A5A5.
- Write then immediate read to 0x40 -> memCanRead low until the write drains; avm_read starts only after avm_write completes.
- Read of 0x80, slave returns 0x12345678 one cycle after accept with no waitrequest -> memReadValid exactly 3 cycles after accept, memReadData=0x12345678, single pulse.
- Flush with dcFlushDone after 5 cycles -> one dcFlushOut pulse; canDCacheFlush/memCanRead/memCanWrite low until done, then all high.
- Reset asserted in RD_WAIT, then a stray readdatavalid -> avm_read=0, no memReadValid, state IDLE, memCanRead=1.

Source files
------------

// File: rtl/tiger_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, lane-enable constants
// and the alignment check used by the optional TIGER_DMEM_MISALIGN_TRAP_EN trap.
package tiger_dmem_responder_pkg;

    typedef enum logic [2:0] {
        DMEM_IDLE     = 3'd0,
        DMEM_RD_ISSUE = 3'd1,
        DMEM_RD_WAIT  = 3'd2,
        DMEM_FL_PULSE = 3'd3,
        DMEM_FL_WAIT  = 3'd4
    } dmem_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte accesses are never misaligned; mem8 wins over mem16.
    function automatic logic is_misaligned(input logic       mem8,
                                           input logic       mem16,
                                           input logic [1:0] addr_lo);
        if (mem8) begin
            return 1'b0;
        end else if (mem16) begin
            return addr_lo[0];
        end
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/tiger_dmem_lanes.sv
// Lane steering for stores: byte enables and lane-replicated write data from size,
// low address bits and right-justified store data.
module tiger_dmem_lanes
    import tiger_dmem_responder_pkg::*;
(
    input  logic        mem8_i,
    input  logic        mem16_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o
);

    always_comb begin
        byteenable_o = BE_WORD;
        writedata_o  = data_i;
        if (mem8_i) begin
            byteenable_o = BE_BYTE0 << addr_lo_i;
            writedata_o  = {4{data_i[7:0]}};
        end else if (mem16_i) begin
            byteenable_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            writedata_o  = {2{data_i[15:0]}};
        end
    end

endmodule

// File: rtl/tiger_dmem_responder.sv
// Execute-stage data-memory responder: posted one-entry write buffer, blocking reads and a
// flush barrier onto Avalon-MM. Define TIGER_DMEM_MISALIGN_TRAP_EN to add the addrError trap.
module tiger_dmem_responder
    import tiger_dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  mem16,
    input  logic                  mem8,
    input  logic [ADDR_WIDTH-1:0] memaddress,
    input  logic [31:0]           memwritedata,
    input  logic                  dCacheFlush,
    output logic                  memCanRead,
    output logic                  memCanWrite,
    output logic                  canDCacheFlush,
    output logic [31:0]           memReadData,
    output logic                  memReadValid,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [3:0]            avm_byteenable,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    output logic                  dcFlushOut,
    input  logic                  dcFlushDone
`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
    ,
    output logic                  addrError
`endif
);

    dmem_state_e           state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [31:0]           rd_data_q;
    logic                  rd_valid_q;

    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [3:0]            wb_be_q, wb_be_d;
    logic [31:0]           wb_data_q, wb_data_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic                  misalign;
    logic                  wb_drain;
    logic                  read_acc, write_acc, flush_acc;

    tiger_dmem_lanes u_lanes (
        .mem8_i       (mem8),
        .mem16_i      (mem16),
        .addr_lo_i    (memaddress[1:0]),
        .data_i       (memwritedata),
        .byteenable_o (lane_be),
        .writedata_o  (lane_wdata)
    );

    assign word_addr = {memaddress[ADDR_WIDTH-1:2], 2'b00};

`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(mem8, mem16, memaddress[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign avm_write = wb_valid_q && (state_q == DMEM_IDLE);
    assign avm_read  = (state_q == DMEM_RD_ISSUE);
    assign wb_drain  = avm_write && !avm_waitrequest;

    assign memCanRead     = (state_q == DMEM_IDLE) && !wb_valid_q;
    assign canDCacheFlush = (state_q == DMEM_IDLE) && !wb_valid_q;
    assign memCanWrite    = ((state_q == DMEM_IDLE) || (state_q == DMEM_RD_ISSUE) ||
                             (state_q == DMEM_RD_WAIT)) && (!wb_valid_q || wb_drain);

    assign read_acc  = memread && memCanRead;
    assign write_acc = memwrite && memCanWrite;
    assign flush_acc = dCacheFlush && canDCacheFlush;

    assign avm_address    = avm_read ? rd_addr_q : wb_addr_q;
    assign avm_byteenable = avm_write ? wb_be_q : (avm_read ? BE_WORD : BE_NONE);
    assign avm_writedata  = wb_data_q;
    assign dcFlushOut     = (state_q == DMEM_FL_PULSE);
    assign memReadData    = rd_data_q;
    assign memReadValid   = rd_valid_q;

    // A store accepted in the drain cycle overwrites the entry, so back-to-back posts have no bubble.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        if (wb_drain) begin
            wb_valid_d = 1'b0;
        end
        if (write_acc && !misalign) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = word_addr;
            wb_be_d    = lane_be;
            wb_data_d  = lane_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_be_q    <= BE_NONE;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_be_q    <= wb_be_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DMEM_IDLE;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                DMEM_IDLE: begin
                    if (read_acc) begin
                        if (misalign) begin
                            // Trapped load: answer immediately with zero so MA cannot stall.
                            rd_data_q  <= '0;
                            rd_valid_q <= 1'b1;
                        end else begin
                            rd_addr_q <= word_addr;
                            state_q   <= DMEM_RD_ISSUE;
                        end
                    end else if (flush_acc) begin
                        state_q <= DMEM_FL_PULSE;
                    end
                end
                DMEM_RD_ISSUE: begin
                    if (!avm_waitrequest) begin
                        state_q <= DMEM_RD_WAIT;
                    end
                end
                DMEM_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        rd_data_q  <= avm_readdata;
                        rd_valid_q <= 1'b1;
                        state_q    <= DMEM_IDLE;
                    end
                end
                DMEM_FL_PULSE: begin
                    state_q <= dcFlushDone ? DMEM_IDLE : DMEM_FL_WAIT;
                end
                DMEM_FL_WAIT: begin
                    if (dcFlushDone) begin
                        state_q <= DMEM_IDLE;
                    end
                end
                default: state_q <= DMEM_IDLE;
            endcase
        end
    end

`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
    logic addr_error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_error_q <= 1'b0;
        end else begin
            addr_error_q <= (read_acc || write_acc) && misalign;
        end
    end

    assign addrError = addr_error_q;
`endif

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(memread && memwrite));

endmodule

// File: tb/tb_tiger_dmem_responder.sv
// Directed self-checking bench for tiger_dmem_responder (default build).
module tb_tiger_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, mem16, mem8;
    logic [31:0] memaddress, memwritedata;
    logic        dCacheFlush;
    logic        memCanRead, memCanWrite, canDCacheFlush;
    logic [31:0] memReadData;
    logic        memReadValid;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic        dcFlushOut, dcFlushDone;
`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
    logic        addr_error;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tiger_dmem_responder #(.ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .memread           (memread),
        .memwrite          (memwrite),
        .mem16             (mem16),
        .mem8              (mem8),
        .memaddress        (memaddress),
        .memwritedata      (memwritedata),
        .dCacheFlush       (dCacheFlush),
        .memCanRead        (memCanRead),
        .memCanWrite       (memCanWrite),
        .canDCacheFlush    (canDCacheFlush),
        .memReadData       (memReadData),
        .memReadValid      (memReadValid),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .dcFlushOut        (dcFlushOut),
        .dcFlushDone       (dcFlushDone)
`ifdef TIGER_DMEM_MISALIGN_TRAP_EN
        ,
        .addrError         (addr_error)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({memCanRead, memCanWrite, canDCacheFlush} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready got %b expected 111", {memCanRead, memCanWrite, canDCacheFlush});
        end
        tests++;
        if ({avm_read, avm_write, memReadValid, dcFlushOut} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes got %b expected 0000",
                     {avm_read, avm_write, memReadValid, dcFlushOut});
        end
        tests++;
        if ({avm_address, avm_byteenable, avm_writedata, memReadData} !== 100'd0) begin
            fails++;
            $display("FAIL reset_buses got addr %h be %b wd %h rd %h expected all zero",
                     avm_address, avm_byteenable, avm_writedata, memReadData);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word_write_wait();
        int wcnt = 0;
        memwrite = 1'b1; mem8 = 1'b0; mem16 = 1'b0;
        memaddress = 32'h100; memwritedata = 32'hDEADBEEF;
        avm_waitrequest = 1'b1;
        tick();
        memwrite = 1'b0;
        for (int i = 0; i < 6; i++) begin
            avm_waitrequest = (i < 2);
            #1;
            if (avm_write) wcnt++;
            if (i == 0) begin
                tests++;
                if ({avm_address, avm_byteenable, avm_writedata} !== {32'h100, 4'b1111, 32'hDEADBEEF}) begin
                    fails++;
                    $display("FAIL word_write_bus got %h/%b/%h expected 00000100/1111/deadbeef",
                             avm_address, avm_byteenable, avm_writedata);
                end
                tests++;
                if (memCanWrite !== 1'b0) begin
                    fails++;
                    $display("FAIL word_write_stalled_canwrite got %b expected 0", memCanWrite);
                end
            end
            if (i == 2) begin
                tests++;
                if (memCanWrite !== 1'b1) begin
                    fails++;
                    $display("FAIL word_write_drain_canwrite got %b expected 1", memCanWrite);
                end
            end
            tick();
        end
        avm_waitrequest = 1'b0;
        tests++;
        if (wcnt !== 3) begin
            fails++;
            $display("FAIL word_write_hold got %0d cycles expected 3", wcnt);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] t_addr [6] = '{32'h203, 32'h102, 32'h300, 32'h001, 32'h107, 32'h203};
        logic [31:0] t_data [6] = '{32'h000000A5, 32'h1234BEEF, 32'h0000CAFE, 32'h00000077,
                                    32'h11223344, 32'h0000ABCD};
        logic [1:0]  t_size [6] = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01};
        logic [3:0]  t_be   [6] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b1100};
        logic [31:0] t_wd   [6] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'hCAFECAFE, 32'h77777777,
                                    32'h11223344, 32'hABCDABCD};
        logic [31:0] t_wa   [6] = '{32'h200, 32'h100, 32'h300, 32'h000, 32'h104, 32'h200};
        for (int i = 0; i < 6; i++) begin
            memwrite = 1'b1;
            {mem8, mem16} = t_size[i];
            memaddress = t_addr[i];
            memwritedata = t_data[i];
            tick();
            memwrite = 1'b0;
            #1;
            tests++;
            if ({avm_write, avm_address, avm_byteenable, avm_writedata} !==
                {1'b1, t_wa[i], t_be[i], t_wd[i]}) begin
                fails++;
                $display("FAIL lanes_%0d got wr %b addr %h be %b wd %h expected 1 %h %b %h", i,
                         avm_write, avm_address, avm_byteenable, avm_writedata,
                         t_wa[i], t_be[i], t_wd[i]);
            end
            tick();
        end
        mem8 = 1'b0;
        mem16 = 1'b0;
        tests++;
        if (avm_write !== 1'b0) begin
            fails++;
            $display("FAIL lanes_drained got avm_write %b expected 0", avm_write);
        end
    endtask

    task automatic test_back_to_back();
        memwrite = 1'b1; memaddress = 32'h500; memwritedata = 32'h1;
        tick();
        memaddress = 32'h504; memwritedata = 32'h2;
        #1;
        tests++;
        if ({avm_write, avm_address, memCanWrite} !== {1'b1, 32'h500, 1'b1}) begin
            fails++;
            $display("FAIL b2b_first got wr %b addr %h canwrite %b expected 1 00000500 1",
                     avm_write, avm_address, memCanWrite);
        end
        tick();
        memwrite = 1'b0;
        #1;
        tests++;
        if ({avm_write, avm_address, avm_writedata} !== {1'b1, 32'h504, 32'h2}) begin
            fails++;
            $display("FAIL b2b_second got wr %b addr %h wd %h expected 1 00000504 00000002",
                     avm_write, avm_address, avm_writedata);
        end
        tick();
    endtask

    task automatic test_write_then_read();
        memwrite = 1'b1; memaddress = 32'h40; memwritedata = 32'h55;
        tick();
        memwrite = 1'b0; memread = 1'b1;
        avm_waitrequest = 1'b1;
        #1;
        tests++;
        if ({memCanRead, avm_write, avm_read} !== 3'b010) begin
            fails++;
            $display("FAIL wr_rd_stall got canread/wr/rd %b expected 010",
                     {memCanRead, avm_write, avm_read});
        end
        tick();
        avm_waitrequest = 1'b0;
        #1;
        tests++;
        if ({memCanRead, avm_write, avm_read} !== 3'b010) begin
            fails++;
            $display("FAIL wr_rd_drain got canread/wr/rd %b expected 010",
                     {memCanRead, avm_write, avm_read});
        end
        tick();
        tests++;
        if ({memCanRead, avm_write, avm_read} !== 3'b100) begin
            fails++;
            $display("FAIL wr_rd_accept got canread/wr/rd %b expected 100",
                     {memCanRead, avm_write, avm_read});
        end
        tick();
        memread = 1'b0;
        #1;
        tests++;
        if ({avm_read, avm_write, avm_address, avm_byteenable} !== {2'b10, 32'h40, 4'b1111}) begin
            fails++;
            $display("FAIL wr_rd_issue got rd %b wr %b addr %h be %b expected 1 0 00000040 1111",
                     avm_read, avm_write, avm_address, avm_byteenable);
        end
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h0;
        tick();
        avm_readdatavalid = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        int first = -1;
        int pulses = 0;
        memread = 1'b1; memaddress = 32'h80;
        #1;
        tests++;
        if (memCanRead !== 1'b1) begin
            fails++;
            $display("FAIL read_canread got %b expected 1", memCanRead);
        end
        tick();
        memread = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            avm_readdatavalid = (i == 2) || (i == 5);
            avm_readdata = (i == 5) ? 32'hBAD0BAD0 : 32'h12345678;
            #1;
            if (i == 1) begin
                tests++;
                if ({avm_read, avm_address} !== {1'b1, 32'h80}) begin
                    fails++;
                    $display("FAIL read_issue got rd %b addr %h expected 1 00000080",
                             avm_read, avm_address);
                end
            end
            if (memReadValid === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            tick();
        end
        avm_readdatavalid = 1'b0;
        tests++;
        if (first !== 3) begin
            fails++;
            $display("FAIL read_latency got %0d expected 3", first);
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL read_pulses got %0d expected 1", pulses);
        end
        tests++;
        if (memReadData !== 32'h12345678) begin
            fails++;
            $display("FAIL read_data got %h expected 12345678", memReadData);
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        int first = -1;
        logic early_ready = 1'b0;
        dCacheFlush = 1'b1;
        #1;
        tests++;
        if (canDCacheFlush !== 1'b1) begin
            fails++;
            $display("FAIL flush_can got %b expected 1", canDCacheFlush);
        end
        tick();
        dCacheFlush = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            dcFlushDone = (i == 5);
            #1;
            if (dcFlushOut === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i <= 5 && (memCanRead || memCanWrite || canDCacheFlush)) early_ready = 1'b1;
            if (i == 6) begin
                tests++;
                if ({memCanRead, memCanWrite, canDCacheFlush} !== 3'b111) begin
                    fails++;
                    $display("FAIL flush_ready_after got %b expected 111",
                             {memCanRead, memCanWrite, canDCacheFlush});
                end
            end
            tick();
        end
        dcFlushDone = 1'b0;
        tests++;
        if (pulses !== 1 || first !== 1) begin
            fails++;
            $display("FAIL flush_pulse got %0d pulses first %0d expected 1 at 1", pulses, first);
        end
        tests++;
        if (early_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready_during got %b expected 0", early_ready);
        end
        // Done arriving in the pulse cycle itself.
        dCacheFlush = 1'b1;
        tick();
        dCacheFlush = 1'b0;
        dcFlushDone = 1'b1;
        tick();
        dcFlushDone = 1'b0;
        #1;
        tests++;
        if ({dcFlushOut, canDCacheFlush} !== 2'b01) begin
            fails++;
            $display("FAIL flush_fast_done got out/can %b expected 01", {dcFlushOut, canDCacheFlush});
        end
    endtask

    task automatic test_reset_mid_read();
        int pulses = 0;
        memread = 1'b1; memaddress = 32'h10;
        tick();
        memread = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hFEEDF00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (memReadValid === 1'b1) pulses++;
            tick();
            avm_readdatavalid = 1'b0;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL rst_read_valid got %0d pulses expected 0", pulses);
        end
        tests++;
        if ({avm_read, memCanRead, canDCacheFlush, memReadData} !== {3'b011, 32'h0}) begin
            fails++;
            $display("FAIL rst_read_state got rd %b canread %b canflush %b data %h expected 0 1 1 0",
                     avm_read, memCanRead, canDCacheFlush, memReadData);
        end
    endtask

    task automatic test_reset_mid_write();
        memwrite = 1'b1; memaddress = 32'h600; memwritedata = 32'h9;
        avm_waitrequest = 1'b1;
        tick();
        memwrite = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if ({avm_write, memCanRead} !== 2'b01) begin
            fails++;
            $display("FAIL rst_write_discard got wr/canread %b expected 01", {avm_write, memCanRead});
        end
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        memread = 1'b0; memwrite = 1'b0; mem16 = 1'b0; mem8 = 1'b0;
        memaddress = '0; memwritedata = '0; dCacheFlush = 1'b0;
        avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        dcFlushDone = 1'b0;
        test_reset();
        test_word_write_wait();
        test_lanes();
        test_back_to_back();
        test_write_then_read();
        test_read_latency();
        test_flush();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
